// File: rtl/i2c_dyn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dyn_pkg
// Brief    : Shared state encoding and TX FIFO field layout for the I2C
//            dynamic-mode sequencer.
// Revision : 1.0  initial release
// ============================================================================
package i2c_dyn_pkg;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ADDR = 3'd1;
    localparam logic [2:0] c_ST_WR   = 3'd2;
    localparam logic [2:0] c_ST_CNT  = 3'd3;
    localparam logic [2:0] c_ST_RD   = 3'd4;

    localparam int c_RW_BIT = 0;

    // Flag positions depend on the payload width, which lives in the modules.
    function automatic int start_bit(input int rcnt_w);
        return rcnt_w;
    endfunction

    function automatic int stop_bit(input int rcnt_w);
        return rcnt_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_dyn_rcnt.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dyn_rcnt
// Brief    : Loadable read-byte down-counter; saturates at zero, coerces a
//            zero load to one and flags the ==0/==1/==2 terminal values.
// Revision : 1.0  initial release
// ============================================================================
module i2c_dyn_rcnt #(
    parameter int RCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [RCNT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic [RCNT_W-1:0] o_cnt,
    output logic              o_is_zero,
    output logic              o_is_one,
    output logic              o_is_two,
    output logic              o_load_zero,
    output logic              o_load_one
);

    localparam logic [RCNT_W-1:0] c_ONE = {{(RCNT_W-1){1'b0}}, 1'b1};
    localparam logic [RCNT_W-1:0] c_TWO = c_ONE + c_ONE;

    logic [RCNT_W-1:0] r_cnt;

    assign o_load_zero = (i_load_val == '0);
    // A zero count is treated as a single-byte read, so both end up at one.
    assign o_load_one  = o_load_zero | (i_load_val == c_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= o_load_zero ? c_ONE : i_load_val;
        end else if (i_dec && !o_is_zero) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_is_zero = (r_cnt == '0);
    assign o_is_one  = (r_cnt == c_ONE);
    assign o_is_two  = (r_cnt == c_TWO);

endmodule
`default_nettype wire

// File: rtl/i2c_dynamic_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dynamic_seq
// Brief    : Dynamic-mode transaction sequencer for the I2C master: decodes
//            TX FIFO command words into control-register set/clear pulses.
// Revision : 1.0  initial release
// ============================================================================
module i2c_dynamic_seq
    import i2c_dyn_pkg::*;
#(
    parameter int RCNT_W = 8,
    parameter int FIFO_W = RCNT_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cr_en,
    input  logic              cr_msms,
    input  logic              tx_fifo_empty,
    input  logic              tx_fifo_rd,
    input  logic [FIFO_W-1:0] tx_fifo_dout,
    input  logic              tx_fifo_wr,
    input  logic [FIFO_W-1:0] tx_fifo_din,
    input  logic              rx_fifo_wr,
    output logic              dyna_msms_set,
    output logic              dyna_msms_clr,
    output logic              dyna_txak_set,
    output logic              dyna_txak_clr,
    output logic              dyna_tx_set,
    output logic              dyna_tx_clr,
    output logic              dyna_rsta_set,
    output logic              dyna_err_cnt0,
    output logic              dyna_busy,
    output logic [RCNT_W-1:0] dyna_rcnt
);

    localparam int c_START_BIT = start_bit(RCNT_W);
    localparam int c_STOP_BIT  = stop_bit(RCNT_W);

    logic [2:0]        r_state;
    logic              r_start_hold;
    logic              r_stop_lat;
    logic              r_load1_pend;

    logic              w_en;
    logic              w_start;
    logic              w_start_set;
    logic              w_start_go;
    logic              w_pop_stop;
    logic              w_pop_rd;
    logic [RCNT_W-1:0] w_payload;
    logic              w_addr_pop;
    logic              w_wr_pop;
    logic              w_cnt_pop;
    logic              w_rx_dec;
    logic              w_rd_txak;
    logic              w_load1_fire;
    logic              w_cnt_zero;
    logic              w_cnt_one;
    logic              w_cnt_two;
    logic              w_load_zero;
    logic              w_load_one;
    logic              w_unused;

    assign w_en      = cr_en & ~rst;
    assign w_unused  = ^tx_fifo_din;

    // A start is seen either at the FIFO head or on a push straight into an
    // empty FIFO; the hold register turns it into a one-shot per head word.
    assign w_start     = (~tx_fifo_empty & tx_fifo_dout[c_START_BIT]) |
                         (tx_fifo_empty & tx_fifo_wr & tx_fifo_din[c_START_BIT]);
    assign w_start_set = w_start & ~r_start_hold;
    assign w_start_go  = w_start_set & w_en;

    assign w_pop_stop = tx_fifo_dout[c_STOP_BIT];
    assign w_pop_rd   = tx_fifo_dout[c_RW_BIT];
    assign w_payload  = tx_fifo_dout[RCNT_W-1:0];

    assign w_addr_pop = w_en & (r_state == c_ST_ADDR) & tx_fifo_rd;
    assign w_wr_pop   = w_en & (r_state == c_ST_WR) & tx_fifo_rd & ~w_start_go;
    assign w_cnt_pop  = w_en & (r_state == c_ST_CNT) & tx_fifo_rd;
    assign w_rx_dec   = w_en & (r_state == c_ST_RD) & rx_fifo_wr;

    i2c_dyn_rcnt #(
        .RCNT_W (RCNT_W)
    ) u_rcnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (~cr_en),
        .i_load      (w_cnt_pop),
        .i_load_val  (w_payload),
        .i_dec       (w_rx_dec),
        .o_cnt       (dyna_rcnt),
        .o_is_zero   (w_cnt_zero),
        .o_is_one    (w_cnt_one),
        .o_is_two    (w_cnt_two),
        .o_load_zero (w_load_zero),
        .o_load_one  (w_load_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_start_hold <= 1'b0;
            r_stop_lat   <= 1'b0;
            r_load1_pend <= 1'b0;
        end else begin
            r_start_hold <= w_start;
            r_load1_pend <= w_cnt_pop & w_load_one;
            if (!cr_en) begin
                r_state    <= c_ST_IDLE;
                r_stop_lat <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_start_go) r_state <= c_ST_ADDR;
                    end
                    c_ST_ADDR: begin
                        if (tx_fifo_rd) begin
                            if (w_pop_rd)        r_state <= c_ST_CNT;
                            else if (w_pop_stop) r_state <= c_ST_IDLE;
                            else                 r_state <= c_ST_WR;
                        end
                    end
                    c_ST_WR: begin
                        if (w_start_go)                    r_state <= c_ST_ADDR;
                        else if (tx_fifo_rd && w_pop_stop) r_state <= c_ST_IDLE;
                    end
                    c_ST_CNT: begin
                        if (tx_fifo_rd) begin
                            r_stop_lat <= w_pop_stop;
                            r_state    <= c_ST_RD;
                        end
                    end
                    c_ST_RD: begin
                        // Without a latched stop the bus stays owned, awaiting a repeated start.
                        if (w_start_go && w_cnt_zero)                   r_state <= c_ST_ADDR;
                        else if (w_rx_dec && w_cnt_one && r_stop_lat) r_state <= c_ST_IDLE;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign w_load1_fire = r_load1_pend & w_en;
    assign w_rd_txak    = w_rx_dec & w_cnt_two;

    assign dyna_msms_set = w_start_go & ~cr_msms;
    assign dyna_rsta_set = w_start_go & cr_msms;
    assign dyna_txak_clr = w_start_go;
    // Read address pops raise both TX pulses; the register gives set priority.
    assign dyna_tx_set   = w_addr_pop & w_pop_rd;
    assign dyna_tx_clr   = w_addr_pop;
    assign dyna_txak_set = w_rd_txak | w_load1_fire;
    assign dyna_msms_clr = (w_addr_pop & ~w_pop_rd & w_pop_stop) |
                           (w_wr_pop & w_pop_stop) |
                           (dyna_txak_set & r_stop_lat);
    assign dyna_err_cnt0 = w_cnt_pop & w_load_zero;
    assign dyna_busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_dynamic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_dynamic_seq
// Brief    : Self-checking bench for i2c_dynamic_seq with a transaction-level
//            reference model and a bench-owned TX FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_dynamic_seq;

    localparam int RW = 12;
    localparam int FW = RW + 2;
    localparam int SB = RW;
    localparam int PB = RW + 1;

    localparam int P_IDLE = 0;
    localparam int P_ADDR = 1;
    localparam int P_WR   = 2;
    localparam int P_CNT  = 3;
    localparam int P_RD   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cr_en;
    logic          cr_msms;
    logic          tx_fifo_empty;
    logic          tx_fifo_rd;
    logic [FW-1:0] tx_fifo_dout;
    logic          tx_fifo_wr;
    logic [FW-1:0] tx_fifo_din;
    logic          rx_fifo_wr;
    logic          dyna_msms_set, dyna_msms_clr;
    logic          dyna_txak_set, dyna_txak_clr;
    logic          dyna_tx_set, dyna_tx_clr;
    logic          dyna_rsta_set, dyna_err_cnt0;
    logic          dyna_busy;
    logic [RW-1:0] dyna_rcnt;

    always #5 clk = ~clk;

    i2c_dynamic_seq #(
        .RCNT_W (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cr_en         (cr_en),
        .cr_msms       (cr_msms),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_rd    (tx_fifo_rd),
        .tx_fifo_dout  (tx_fifo_dout),
        .tx_fifo_wr    (tx_fifo_wr),
        .tx_fifo_din   (tx_fifo_din),
        .rx_fifo_wr    (rx_fifo_wr),
        .dyna_msms_set (dyna_msms_set),
        .dyna_msms_clr (dyna_msms_clr),
        .dyna_txak_set (dyna_txak_set),
        .dyna_txak_clr (dyna_txak_clr),
        .dyna_tx_set   (dyna_tx_set),
        .dyna_tx_clr   (dyna_tx_clr),
        .dyna_rsta_set (dyna_rsta_set),
        .dyna_err_cnt0 (dyna_err_cnt0),
        .dyna_busy     (dyna_busy),
        .dyna_rcnt     (dyna_rcnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [FW-1:0] q[$];

    // Reference model: transaction phase, bytes left, stop intent, start edge memory
    // and a pending "last byte after load" acknowledge.
    int m_ph;
    int m_rcnt;
    bit m_lat;
    bit m_hold;
    bit m_l1;

    // Pulse vector order: msms_set msms_clr txak_set txak_clr tx_set tx_clr rsta_set err_cnt0
    logic [7:0] obs_p;
    int         obs_rcnt;
    bit         obs_busy;

    function automatic logic [FW-1:0] mk(input bit st, input bit sp, input int pay);
        logic [FW-1:0] w;
        w = '0;
        w[RW-1:0] = RW'(pay);
        w[SB] = st;
        w[PB] = sp;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_rcnt = 0; m_lat = 0; m_hold = 0; m_l1 = 0;
    endtask

    task automatic refresh_fifo();
        tx_fifo_empty = (q.size() == 0);
        tx_fifo_dout  = (q.size() != 0) ? q[0] : '0;
    endtask

    // One clock cycle: compare against the model, advance the model, then the FIFO.
    task automatic step();
        logic [FW-1:0] w;
        logic [7:0]    ep;
        logic [7:0]    ap;
        bit en, st, go, apop, wpop, cpop, rxe, ts, mc;
        int pay;
        #1;
        if (rst) model_reset();
        w   = (q.size() != 0) ? q[0] : '0;
        pay = int'(w[RW-1:0]);
        en  = cr_en && !rst;
        st  = (q.size() != 0 && w[SB]) || (q.size() == 0 && tx_fifo_wr && tx_fifo_din[SB]);
        go  = st && !m_hold && en;
        apop = en && m_ph == P_ADDR && tx_fifo_rd;
        wpop = en && m_ph == P_WR && tx_fifo_rd && !go;
        cpop = en && m_ph == P_CNT && tx_fifo_rd;
        rxe  = en && m_ph == P_RD && rx_fifo_wr;
        ts = (rxe && m_rcnt == 2) || (en && m_l1);
        mc = (apop && !w[0] && w[PB]) || (wpop && w[PB]) || (ts && m_lat);
        ep = {go && !cr_msms, mc, ts, go, apop && w[0], apop, go && cr_msms, cpop && pay == 0};
        ap = {dyna_msms_set, dyna_msms_clr, dyna_txak_set, dyna_txak_clr,
              dyna_tx_set, dyna_tx_clr, dyna_rsta_set, dyna_err_cnt0};
        chk("pulses", 32'(ap), 32'(ep));
        chk("rcnt", 32'(dyna_rcnt), 32'(m_rcnt));
        chk("busy", 32'(dyna_busy), 32'(m_ph != P_IDLE));
        obs_p = ap; obs_rcnt = int'(dyna_rcnt); obs_busy = dyna_busy;

        if (rst) begin
            model_reset();
        end else begin
            m_hold = st;
            m_l1   = cpop && (pay <= 1);
            if (!cr_en) begin
                m_ph = P_IDLE; m_rcnt = 0; m_lat = 0;
            end else if (m_ph == P_IDLE) begin
                if (go) m_ph = P_ADDR;
            end else if (m_ph == P_ADDR) begin
                if (tx_fifo_rd) m_ph = w[0] ? P_CNT : (w[PB] ? P_IDLE : P_WR);
            end else if (m_ph == P_WR) begin
                if (go) m_ph = P_ADDR;
                else if (tx_fifo_rd && w[PB]) m_ph = P_IDLE;
            end else if (m_ph == P_CNT) begin
                if (tx_fifo_rd) begin
                    m_rcnt = (pay == 0) ? 1 : pay;
                    m_lat  = w[PB];
                    m_ph   = P_RD;
                end
            end else begin
                if (go && m_rcnt == 0) m_ph = P_ADDR;
                else if (rxe) begin
                    if (m_rcnt == 1 && m_lat) m_ph = P_IDLE;
                    if (m_rcnt > 0) m_rcnt--;
                end
            end
        end

        @(posedge clk);
        #1;
        if (tx_fifo_rd && q.size() != 0) void'(q.pop_front());
        if (tx_fifo_wr) q.push_back(tx_fifo_din);
        refresh_fifo();
        @(negedge clk);
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [FW-1:0] din, input bit rxw);
        tx_fifo_rd = rd; tx_fifo_wr = wr; tx_fifo_din = din; rx_fifo_wr = rxw;
        step();
        tx_fifo_rd = 1'b0; tx_fifo_wr = 1'b0; tx_fifo_din = '0; rx_fifo_wr = 1'b0;
    endtask

    task automatic push(input logic [FW-1:0] w);
        cyc(1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic rx();
        cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic gap();
        idle($urandom_range(0, 2));
    endtask

    initial begin
        int at;
        int nw, cnt, addr;
        bit isrd, stp;
        logic [FW-1:0] words[$];

        rst = 1'b1; cr_en = 1'b1; cr_msms = 1'b0;
        tx_fifo_rd = 1'b0; tx_fifo_wr = 1'b0; tx_fifo_din = '0; rx_fifo_wr = 1'b0;
        model_reset();
        refresh_fifo();
        @(negedge clk);
        idle(2);
        chk("lit_reset_busy", 32'(obs_busy), 32'd0);
        chk("lit_reset_rcnt", 32'(obs_rcnt), 32'd0);
        rst = 1'b0;
        idle(1);

        // Write transaction with stop
        push(mk(1, 0, 'hA0));
        chk("lit_wr_start", 32'(obs_p), 32'h90);
        push(mk(0, 0, 'h11));
        push(mk(0, 1, 'h22));
        idle(1);
        pop();
        chk("lit_wr_addr_pop", 32'(obs_p), 32'h04);
        pop();
        pop();
        chk("lit_wr_stop_pop", 32'(obs_p), 32'h40);
        idle(1);
        chk("lit_wr_idle", 32'(obs_busy), 32'd0);

        // Read 3 bytes with stop
        push(mk(1, 0, 'hA1));
        push(mk(0, 1, 3));
        pop();
        chk("lit_rd_addr_pop", 32'(obs_p), 32'h0C);
        pop();
        idle(1);
        chk("lit_rd_rcnt3", 32'(obs_rcnt), 32'd3);
        rx();
        rx();
        chk("lit_rd_2nd_rx", 32'(obs_p), 32'h60);
        rx();
        idle(1);
        chk("lit_rd_idle", 32'(obs_busy), 32'd0);

        // Wide count of 256
        push(mk(1, 0, 'hA1));
        push(mk(0, 1, 'h100));
        pop();
        pop();
        idle(1);
        chk("lit_256_rcnt", 32'(obs_rcnt), 32'd256);
        at = -1;
        for (int i = 1; i <= 256; i++) begin
            rx();
            if (obs_p[5]) at = i;
        end
        chk("lit_256_txak_idx", 32'(at), 32'd255);
        idle(1);
        chk("lit_256_idle", 32'(obs_busy), 32'd0);

        // Count 0 and count 1
        push(mk(1, 0, 'hA1));
        push(mk(0, 1, 0));
        pop();
        pop();
        chk("lit_cnt0_err", 32'(obs_p), 32'h01);
        idle(1);
        chk("lit_cnt0_ack", 32'(obs_p), 32'h60);
        rx();
        idle(1);
        push(mk(1, 0, 'hA1));
        push(mk(0, 1, 1));
        pop();
        pop();
        chk("lit_cnt1_noerr", 32'(obs_p), 32'h00);
        idle(1);
        chk("lit_cnt1_ack", 32'(obs_p), 32'h60);
        rx();
        idle(1);

        // Write then repeated start while bus owned
        push(mk(1, 0, 'hA0));
        push(mk(0, 0, 'h11));
        pop();
        pop();
        cr_msms = 1'b1;
        push(mk(1, 0, 'hA1));
        chk("lit_rsta", 32'(obs_p), 32'h12);
        pop();
        chk("lit_rsta_addr", 32'(obs_p), 32'h0C);
        push(mk(0, 1, 1));
        pop();
        idle(2);
        rx();
        idle(1);
        cr_msms = 1'b0;

        // Enable loss mid-read, then reset mid-address
        push(mk(1, 0, 'hA1));
        push(mk(0, 0, 5));
        pop();
        pop();
        idle(1);
        chk("lit_abort_rcnt5", 32'(obs_rcnt), 32'd5);
        cr_en = 1'b0;
        idle(1);
        idle(1);
        chk("lit_abort_rcnt0", 32'(obs_rcnt), 32'd0);
        chk("lit_abort_idle", 32'(obs_busy), 32'd0);
        push(mk(1, 0, 'hA0));
        chk("lit_dis_quiet", 32'(obs_p), 32'h00);
        pop();
        cr_en = 1'b1;
        idle(1);
        push(mk(1, 0, 'hA0));
        chk("lit_reen_start", 32'(obs_p), 32'h90);
        rst = 1'b1;
        q.delete();
        refresh_fifo();
        idle(1);
        rst = 1'b0;
        idle(1);
        chk("lit_rst_idle", 32'(obs_busy), 32'd0);
        push(mk(1, 0, 'hA0));
        chk("lit_post_rst_start", 32'(obs_p), 32'h90);
        pop();
        push(mk(0, 1, 'h33));
        pop();
        idle(1);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            cr_msms = 1'($urandom_range(0, 1));
            isrd = 1'($urandom_range(0, 1));
            stp  = ($urandom_range(0, 2) != 0);
            addr = int'($urandom_range(0, 255));
            words.delete();
            cnt = 0;
            if (isrd) begin
                cnt = int'($urandom_range(0, 5));
                words.push_back(mk(1, 0, addr | 1));
                words.push_back(mk(0, stp, cnt));
            end else begin
                nw = int'($urandom_range(0, 3));
                words.push_back(mk(1, (nw == 0) && stp, addr & 'hFE));
                for (int k = 0; k < nw; k++)
                    words.push_back(mk(0, (k == nw - 1) && stp, int'($urandom_range(0, 255))));
            end
            foreach (words[k]) begin
                push(words[k]);
                gap();
            end
            foreach (words[k]) begin
                pop();
                gap();
            end
            if (isrd) begin
                for (int k = 0; k < ((cnt == 0) ? 1 : cnt); k++) begin
                    rx();
                    gap();
                end
                if ($urandom_range(0, 3) == 0) rx();
            end
            idle(1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_dynamic_seq.md
Name: i2c_dynamic_seq

Overview:
Parametrised successor of the dynamic-mode controller for the I2C master. Decodes command words from the TX FIFO (start/stop flags, address, read count) and emits single-cycle set/clear pulses for the control-register bits MSMS, TXAK, TX and RSTA. Replaces the implicit one-shot logic with an explicit transaction FSM, a wider read counter, latched stop intent, count-zero error reporting and a clean abort on enable loss. Sits between the TX/RX FIFOs and the control register, beside the byte-level master engine.

Parameters:
RCNT_W, 8, read-count width; also the TX FIFO payload width (must be >= 8)
FIFO_W, RCNT_W+2, TX FIFO word width: {stop, start, payload[RCNT_W-1:0]}

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cr_en  in  1  core enable from control register
cr_msms  in  1  current MSMS (bus owned) bit
tx_fifo_empty  in  1  TX FIFO empty
tx_fifo_rd  in  1  TX FIFO pop; tx_fifo_dout is the popped word in this cycle
tx_fifo_dout  in  FIFO_W  TX FIFO head word
tx_fifo_wr  in  1  TX FIFO push
tx_fifo_din  in  FIFO_W  TX FIFO push word
rx_fifo_wr  in  1  one byte received
dyna_msms_set / dyna_msms_clr  out  1  each  MSMS set/clear pulse
dyna_txak_set / dyna_txak_clr  out  1  each  TXAK set/clear pulse
dyna_tx_set / dyna_tx_clr  out  1  each  TX-direction set/clear pulse
dyna_rsta_set  out  1  repeated-start pulse
dyna_err_cnt0  out  1  pulse: read count of zero popped
dyna_busy  out  1  FSM not IDLE
dyna_rcnt  out  RCNT_W  bytes still to receive

Behaviour:
- Reset: all outputs 0, state IDLE, rcnt 0, stop_lat 0, start_hold 0.
- start = (!empty & dout[RCNT_W]) | (empty & wr & din[RCNT_W]); start_set = start & !start_hold; start_hold <= start each cycle.
- start_set & cr_en: txak_clr pulse same cycle; msms_set if !cr_msms, else rsta_set. Never both.
- States: IDLE, ADDR, WR, CNT, RD.
- IDLE/WR/RD --start_set&cr_en--> ADDR (RD only once rcnt==0).
- ADDR, on pop: dout[0]=1 (read): tx_set and tx_clr pulse together (inherited dual pulse; register priority resolves) -> CNT. dout[0]=0: tx_clr -> WR; if stop bit set, msms_clr same cycle -> IDLE.
- WR, on pop: stop bit set -> msms_clr same cycle -> IDLE.
- CNT, on pop: rcnt <= payload; stop_lat <= stop bit -> RD. Payload 0: err_cnt0 pulse, rcnt loaded as 1. Loaded count 1 (including coerced 0): txak_set the cycle after load, plus msms_clr same cycle if stop_lat.
- RD, on rx_fifo_wr: rcnt decrements, saturating at 0. rcnt==2: txak_set, plus msms_clr if stop_lat. rcnt 1->0: -> IDLE if stop_lat, else stay in RD, waiting for repeated start.
- Latency: every pulse is combinational on its qualifying input, or exactly one cycle after count load; each pulse is high for exactly one cycle.
- Simultaneous events: a pop in CNT wins over rx_fifo_wr; start_set in WR is acted on before a same-cycle pop.
- cr_en low: FSM -> IDLE next cycle; rcnt and stop_lat clear; all dyna_* pulses suppressed while low.
- Width: rcnt is RCNT_W bits, unsigned, no wrap below 0.

Decomposition:
- Shared package i2c_dyn_pkg: state encoding, field indices START_BIT=RCNT_W, STOP_BIT=RCNT_W+1, RW_BIT=0.
- Sub-module i2c_dyn_rcnt: loadable down-counter with saturation, zero-coerce and ==1/==2 flags.
- FSM and pulse decode stay in the top.

Test Plan:
- Write: push {start,0xA0}, {0,0x11}, {stop,0x22}, cr_msms=0 -> msms_set on first push; tx_clr on address pop; msms_clr on third pop; busy returns 0.
- Read 3 bytes: {start,0xA1}, {stop,3}; three rx_fifo_wr -> tx_set+tx_clr on address pop, rcnt=3; txak_set+msms_clr on 2nd rx write; IDLE after 3rd.
- RCNT_W=12, count 0x100 -> rcnt counts 256 down; txak_set exactly at the 255th rx_fifo_wr.
- Count 0 and count 1 -> err_cnt0 only for 0; both give txak_set (+msms_clr with stop) the cycle after load.
- Write then repeated start, cr_msms=1 -> rsta_set, no msms_set, txak_clr same cycle; FSM -> ADDR.
- cr_en dropped mid-RD (rcnt=5), then rst asserted mid-ADDR -> IDLE, rcnt=0, no pulses; after re-enable a fresh start word gives a normal msms_set.
